// File: rtl/uart1_rx_if.sv
// UART1 receiver interface: serial line in, received byte and status strobes out.
// With UART1_RX_PARITY_EN defined, the parity_err strobe is added.
interface uart1_rx_if;
    logic       serial_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;
`ifdef UART1_RX_PARITY_EN
    logic       parity_err;

    modport master (
        input  serial_in,
        output rx_data, rx_valid, frame_err, busy, parity_err
    );
    modport slave (
        output serial_in,
        input  rx_data, rx_valid, frame_err, busy, parity_err
    );
`else
    modport master (
        input  serial_in,
        output rx_data, rx_valid, frame_err, busy
    );
    modport slave (
        output serial_in,
        input  rx_data, rx_valid, frame_err, busy
    );
`endif
endinterface

// File: rtl/uart1_rx.sv
// UART1 receive path: deserialises 8N1 frames (start, 8 data bits LSB first,
// stop) and presents each byte with a one-cycle rx_valid strobe.
// Optional feature macro UART1_RX_PARITY_EN: adds an even-parity bit before
// the stop bit and a parity_err strobe.
module uart1_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    uart1_rx_if.master rx
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  MID_CNT  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART1_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   prev_q;
    logic [CNT_W-1:0]       clk_cnt_q, clk_cnt_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q;
    logic                   shift_en;
    logic                   valid_d;
    logic                   ferr_d;
`ifdef UART1_RX_PARITY_EN
    logic                   par_q;
    logic                   par_en;
    logic                   perr_d;
`endif

    assign s       = sync_q[SYNC_STAGES-1];
    assign rx.busy = (state_q != S_IDLE);

    // Synchronise the asynchronous line and keep last cycle's value for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx.serial_in};
            prev_q <= s;
        end
    end

    // FSM state and bit/clock counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Next-state logic; every sample point falls at the middle of a bit.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q + 1'b1;
        bit_cnt_d = bit_cnt_q;
        shift_en  = 1'b0;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
`ifdef UART1_RX_PARITY_EN
        par_en    = 1'b0;
        perr_d    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                clk_cnt_d = '0;
                // Only a falling edge starts a frame, so a held-low line never retriggers.
                if (!s && prev_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (clk_cnt_q == MID_CNT) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (clk_cnt_q == FULL_CNT) begin
                    clk_cnt_d = '0;
                    shift_en  = 1'b1;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART1_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART1_RX_PARITY_EN
            S_PARITY: begin
                if (clk_cnt_q == FULL_CNT) begin
                    clk_cnt_d = '0;
                    par_en    = 1'b1;
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (clk_cnt_q == FULL_CNT) begin
                    clk_cnt_d = '0;
                    state_d   = S_IDLE;
                    if (!s) begin
                        ferr_d = 1'b1;
`ifdef UART1_RX_PARITY_EN
                    end else if (^{shift_q, par_q}) begin
                        perr_d = 1'b1;
`endif
                    end else begin
                        valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Data shift register (LSB arrives first, enters at bit 7) and parity capture.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            shift_q <= {s, shift_q[7:1]};
        end
`ifdef UART1_RX_PARITY_EN
        if (par_en) begin
            par_q <= s;
        end
`endif
    end

    // Registered output byte and one-cycle status strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx.rx_data    <= '0;
            rx.rx_valid   <= 1'b0;
            rx.frame_err  <= 1'b0;
`ifdef UART1_RX_PARITY_EN
            rx.parity_err <= 1'b0;
`endif
        end else begin
            rx.rx_valid   <= valid_d;
            rx.frame_err  <= ferr_d;
`ifdef UART1_RX_PARITY_EN
            rx.parity_err <= perr_d;
`endif
            if (valid_d) begin
                rx.rx_data <= shift_q;
            end
        end
    end

endmodule

// File: tb/tb_uart1_rx.sv
// Directed testbench for uart1_rx (CLKS_PER_BIT=16, SYNC_STAGES=2).
module tb_uart1_rx;

    localparam int CPB = 16;
`ifdef UART1_RX_PARITY_EN
    localparam int FRAME_CYC = 11 * CPB;
`else
    localparam int FRAME_CYC = 10 * CPB;
`endif
    // Sync delay + start mid-point + data (and parity) bits + stop mid-sample + output register.
    localparam int LAT = 2 + FRAME_CYC - CPB / 2 + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart1_rx_if intf ();

    uart1_rx #(
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx (intf)
    );

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    int valid_cnt = 0;
    int ferr_cnt  = 0;
    int perr_cnt  = 0;
    int excl_viol = 0;
    int last_vcyc = 0;
    int prev_vcyc = 0;
    logic [7:0] last_data = 8'h00;
    logic [7:0] prev_data = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor, sampled on the falling edge.
    always @(negedge clk) begin
        int hits;
        hits = int'(intf.rx_valid) + int'(intf.frame_err);
`ifdef UART1_RX_PARITY_EN
        hits = hits + int'(intf.parity_err);
        if (intf.parity_err === 1'b1) perr_cnt = perr_cnt + 1;
`endif
        if (hits > 1) excl_viol = excl_viol + 1;
        if (intf.frame_err === 1'b1) ferr_cnt = ferr_cnt + 1;
        if (intf.rx_valid === 1'b1) begin
            valid_cnt = valid_cnt + 1;
            prev_vcyc = last_vcyc;
            last_vcyc = cyc;
            prev_data = last_data;
            last_data = intf.rx_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        intf.serial_in = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART1_RX_PARITY_EN
        send_bit(par);
`else
        if (par === 1'bx) $display("note: unknown parity argument");
`endif
        send_bit(stop);
    endtask

    initial begin
        int vb, fb, t0, lat;
        rst = 1'b0;
        intf.serial_in = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_rx_data", 32'(intf.rx_data), 32'h00);
        check("rst_rx_valid", 32'(intf.rx_valid), 32'h0);
        check("rst_frame_err", 32'(intf.frame_err), 32'h0);
        check("rst_busy", 32'(intf.busy), 32'h0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_busy", 32'(intf.busy), 32'h0);

        // Single frame 0xAC
        vb = valid_cnt; fb = ferr_cnt; t0 = cyc;
        send_frame(8'hAC, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        lat = last_vcyc - t0;
        check("ac_valid_count", 32'(valid_cnt - vb), 32'd1);
        check("ac_rx_data", 32'(intf.rx_data), 32'hAC);
        check("ac_frame_err", 32'(ferr_cnt - fb), 32'd0);
        check("ac_busy_after", 32'(intf.busy), 32'h0);
        check("ac_latency_window", 32'(lat >= LAT - 1 && lat <= LAT + 1), 32'd1);

        // Back-to-back 0x55 then 0xFF
        vb = valid_cnt;
        send_frame(8'h55, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        check("b2b_valid_count", 32'(valid_cnt - vb), 32'd2);
        check("b2b_first_data", 32'(prev_data), 32'h55);
        check("b2b_second_data", 32'(last_data), 32'hFF);
        check("b2b_spacing", 32'(last_vcyc - prev_vcyc), 32'(FRAME_CYC));

        // 3-cycle glitch on an idle line
        vb = valid_cnt; fb = ferr_cnt;
        intf.serial_in = 1'b0;
        repeat (3) @(negedge clk);
        intf.serial_in = 1'b1;
        @(negedge clk);
        check("glitch_busy_seen", 32'(intf.busy), 32'h1);
        repeat (11) @(negedge clk);
        check("glitch_busy_clear", 32'(intf.busy), 32'h0);
        check("glitch_no_valid", 32'(valid_cnt - vb), 32'd0);
        check("glitch_no_ferr", 32'(ferr_cnt - fb), 32'd0);

        // 0x3C with stop bit low, then line held low (break)
        vb = valid_cnt; fb = ferr_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        intf.serial_in = 1'b0;
        repeat (40) @(negedge clk);
        check("ferr_count", 32'(ferr_cnt - fb), 32'd1);
        check("ferr_no_valid", 32'(valid_cnt - vb), 32'd0);
        check("ferr_data_held", 32'(intf.rx_data), 32'hFF);
        check("break_no_retrigger", 32'(intf.busy), 32'h0);
        intf.serial_in = 1'b1;
        repeat (30) @(negedge clk);
        check("break_release_idle", 32'(intf.busy), 32'h0);
        check("break_ferr_once", 32'(ferr_cnt - fb), 32'd1);

        // Reset asserted at data bit 4 of 0x81, then a clean 0x81
        vb = valid_cnt; fb = ferr_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        rst = 1'b0;
        intf.serial_in = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst_rx_data", 32'(intf.rx_data), 32'h00);
        check("midrst_busy", 32'(intf.busy), 32'h0);
        check("midrst_rx_valid", 32'(intf.rx_valid), 32'h0);
        check("midrst_frame_err", 32'(intf.frame_err), 32'h0);
        repeat (CPB - 4) @(negedge clk);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_no_strobe", 32'(valid_cnt - vb + ferr_cnt - fb), 32'd0);
        send_frame(8'h81, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        check("post_rst_valid_count", 32'(valid_cnt - vb), 32'd1);
        check("post_rst_rx_data", 32'(intf.rx_data), 32'h81);

`ifdef UART1_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so the parity bit must be 1
        vb = valid_cnt;
        send_frame(8'h07, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        check("par_good_valid", 32'(valid_cnt - vb), 32'd1);
        check("par_good_data", 32'(intf.rx_data), 32'h07);
        vb = valid_cnt;
        fb = perr_cnt;
        send_frame(8'h07, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        check("par_bad_perr", 32'(perr_cnt - fb), 32'd1);
        check("par_bad_no_valid", 32'(valid_cnt - vb), 32'd0);
`endif

        check("strobes_exclusive", 32'(excl_viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
